// File: rtl/doled_rx.sv
// doled_rx: receive-side decoder for the doled LED-string SPI stream.
// Oversamples sck/mosi on the system clock, hunts for the all-zero start
// frame, decodes each LED frame into brightness/colour fields with an index,
// and checks the all-ones end frame.
// Optional feature: define DOLED_RX_TIMEOUT_EN to build the idle timeout that
// abandons partial frames after IDLE_TIMEOUT clocks without an sck rise.
module doled_rx #(
    parameter int LED_COUNT    = 46,
    parameter int IDLE_TIMEOUT = 4096
) (
    input  logic       doled_rx_clk,
    input  logic       doled_rx_reset_n,
    input  logic       mosi,
    input  logic       sck,
    output logic       led_valid,
    output logic [7:0] led_index,
    output logic [4:0] bright,
    output logic [7:0] blue,
    output logic [7:0] green,
    output logic [7:0] red,
    output logic       start_seen,
    output logic       end_seen,
    output logic       proto_err,
    output logic       in_string
);

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_LEDS = 2'd1,
        S_END  = 2'd2
    } state_t;

    if (LED_COUNT < 1 || LED_COUNT > 255 || IDLE_TIMEOUT < 1) begin : g_bad_config
        $error("doled_rx: LED_COUNT must be 1..255 and IDLE_TIMEOUT must be positive");
    end

    logic        sck_s1_q, sck_s2_q, sck_s3_q;
    logic        mosi_s1_q, mosi_s2_q;
    logic        rise;
    logic        tmo_fire;
    logic [31:0] shift_d;

    // The window is the 31 most recent bits plus the incoming bit, so only
    // 31 bits of history need to be stored.
    logic [30:0] shreg_q;
    logic [4:0]  bitcnt_q;
    logic        full_q;
    logic [7:0]  idx_q;
    state_t      state_q;

    logic        led_valid_q, start_q, end_q, err_q;
    logic [7:0]  led_index_q, blue_q, green_q, red_q;
    logic [4:0]  bright_q;

    // Two-flop synchronisers for sck and mosi, plus a third sck flop for edge detect
    always_ff @(posedge doled_rx_clk or negedge doled_rx_reset_n) begin
        if (!doled_rx_reset_n) begin
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_s3_q  <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sck_s1_q  <= sck;
            sck_s2_q  <= sck_s1_q;
            sck_s3_q  <= sck_s2_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    assign rise    = sck_s2_q & ~sck_s3_q;
    assign shift_d = {shreg_q, mosi_s2_q};

`ifdef DOLED_RX_TIMEOUT_EN
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    logic [TW-1:0] tmo_q;

    assign tmo_fire = !rise && (tmo_q == TW'(IDLE_TIMEOUT - 1));

    // Idle counter: clears on every sck rise, saturates at IDLE_TIMEOUT
    always_ff @(posedge doled_rx_clk or negedge doled_rx_reset_n) begin
        if (!doled_rx_reset_n) begin
            tmo_q <= '0;
        end else if (rise) begin
            tmo_q <= '0;
        end else if (tmo_q != TW'(IDLE_TIMEOUT)) begin
            tmo_q <= tmo_q + TW'(1);
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    // Framing FSM: shifts bits, aligns on the start frame, decodes LED and end
    // frames, and registers all pulses and field outputs. full_q marks that
    // the window holds 32 genuinely received bits since entering HUNT, so the
    // zeroed history after reset or an abandoned string cannot fake a start.
    always_ff @(posedge doled_rx_clk or negedge doled_rx_reset_n) begin
        if (!doled_rx_reset_n) begin
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            full_q      <= 1'b0;
            idx_q       <= '0;
            state_q     <= S_HUNT;
            led_valid_q <= 1'b0;
            start_q     <= 1'b0;
            end_q       <= 1'b0;
            err_q       <= 1'b0;
            led_index_q <= '0;
            bright_q    <= '0;
            blue_q      <= '0;
            green_q     <= '0;
            red_q       <= '0;
        end else begin
            led_valid_q <= 1'b0;
            start_q     <= 1'b0;
            end_q       <= 1'b0;
            err_q       <= 1'b0;
            if (rise) begin
                shreg_q  <= shift_d[30:0];
                bitcnt_q <= bitcnt_q + 5'd1;
                case (state_q)
                    S_HUNT: begin
                        if (bitcnt_q == 5'd31) begin
                            full_q <= 1'b1;
                        end
                        if (shift_d == 32'h0 && (full_q || bitcnt_q == 5'd31)) begin
                            start_q  <= 1'b1;
                            bitcnt_q <= '0;
                            idx_q    <= '0;
                            state_q  <= S_LEDS;
                        end
                    end
                    S_LEDS: begin
                        if (bitcnt_q == 5'd31) begin
                            if (shift_d[31:29] == 3'b111) begin
                                led_valid_q <= 1'b1;
                                led_index_q <= idx_q;
                                bright_q    <= shift_d[28:24];
                                blue_q      <= shift_d[23:16];
                                green_q     <= shift_d[15:8];
                                red_q       <= shift_d[7:0];
                                if (idx_q != 8'hFF) begin
                                    idx_q <= idx_q + 8'd1;
                                end
                                if (idx_q == 8'(LED_COUNT - 1)) begin
                                    state_q <= S_END;
                                end
                            end else if (shift_d == 32'h0) begin
                                start_q <= 1'b1;
                                idx_q   <= '0;
                            end else begin
                                err_q   <= 1'b1;
                                full_q  <= 1'b0;
                                state_q <= S_HUNT;
                            end
                        end
                    end
                    S_END: begin
                        if (bitcnt_q == 5'd31) begin
                            if (shift_d == 32'hFFFF_FFFF) begin
                                end_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                            full_q  <= 1'b0;
                            state_q <= S_HUNT;
                        end
                    end
                    default: begin
                        state_q <= S_HUNT;
                    end
                endcase
            end else if (tmo_fire && (state_q != S_HUNT || bitcnt_q != 5'd0 || full_q)) begin
                if (state_q != S_HUNT) begin
                    err_q <= 1'b1;
                end
                shreg_q  <= '0;
                bitcnt_q <= '0;
                full_q   <= 1'b0;
                state_q  <= S_HUNT;
            end
        end
    end

    assign led_valid  = led_valid_q;
    assign led_index  = led_index_q;
    assign bright     = bright_q;
    assign blue       = blue_q;
    assign green      = green_q;
    assign red        = red_q;
    assign start_seen = start_q;
    assign end_seen   = end_q;
    assign proto_err  = err_q;
    assign in_string  = (state_q != S_HUNT);

endmodule

// File: tb/tb_doled_rx.sv
// tb_doled_rx: randomized scoreboard bench for doled_rx.
// Stimulus tasks push the events each word must produce; a monitor on the
// falling clock edge pops and compares whenever the DUT pulses an event.
module tb_doled_rx;

    localparam int KSTART = 0;
    localparam int KLED   = 1;
    localparam int KEND   = 2;
    localparam int KERR   = 3;

    typedef struct {
        int kind;
        int idx;
        int br;
        int bl;
        int gr;
        int rd;
    } evt_t;

    logic       clk = 1'b0;
    logic       rstN;
    logic       mosi;
    logic       sck;
    logic       ledValid;
    logic [7:0] ledIndex;
    logic [4:0] bright;
    logic [7:0] blue, green, red;
    logic       startSeen, endSeen, protoErr, inString;

    evt_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    doled_rx #(
        .LED_COUNT   (46),
        .IDLE_TIMEOUT(4096)
    ) dut (
        .doled_rx_clk    (clk),
        .doled_rx_reset_n(rstN),
        .mosi            (mosi),
        .sck             (sck),
        .led_valid       (ledValid),
        .led_index       (ledIndex),
        .bright          (bright),
        .blue            (blue),
        .green           (green),
        .red             (red),
        .start_seen      (startSeen),
        .end_seen        (endSeen),
        .proto_err       (protoErr),
        .in_string       (inString)
    );

    // Single comparison point: every check steps the counters here
    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " led_valid"}, int'(ledValid), 0);
        checkOutput({tag, " led_index"}, int'(ledIndex), 0);
        checkOutput({tag, " bright"}, int'(bright), 0);
        checkOutput({tag, " blue"}, int'(blue), 0);
        checkOutput({tag, " green"}, int'(green), 0);
        checkOutput({tag, " red"}, int'(red), 0);
        checkOutput({tag, " start_seen"}, int'(startSeen), 0);
        checkOutput({tag, " end_seen"}, int'(endSeen), 0);
        checkOutput({tag, " proto_err"}, int'(protoErr), 0);
        checkOutput({tag, " in_string"}, int'(inString), 0);
    endtask

    task automatic pushEvt(input int kind, input int idx, input int br, input int bl,
                           input int gr, input int rd);
        evt_t e;
        e.kind = kind;
        e.idx  = idx;
        e.br   = br;
        e.bl   = bl;
        e.gr   = gr;
        e.rd   = rd;
        expQ.push_back(e);
    endtask

    function automatic logic [31:0] ledWord(input int br, input int bl, input int gr, input int rd);
        return {3'b111, 5'(br), 8'(bl), 8'(gr), 8'(rd)};
    endfunction

    // One serial bit: data set while sck is low, then a 3-clock high phase
    task automatic sendBit(input logic b);
        mosi = b;
        repeat ($urandom_range(3, 4)) @(negedge clk);
        sck = 1'b1;
        repeat (3) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) begin
            sendBit(w[i]);
        end
    endtask

    task automatic sendStart();
        pushEvt(KSTART, 0, 0, 0, 0, 0);
        sendWord(32'h0);
    endtask

    task automatic sendLed(input int idx, input bit fixedCol);
        int br, bl, gr, rd;
        if (fixedCol) begin
            br = 31; bl = 8'h80; gr = 8'h02; rd = 8'h80;
        end else begin
            br = $urandom_range(0, 31);
            bl = $urandom_range(0, 255);
            gr = $urandom_range(0, 255);
            rd = $urandom_range(0, 255);
        end
        pushEvt(KLED, idx, br, bl, gr, rd);
        sendWord(ledWord(br, bl, gr, rd));
    endtask

    // A whole string: start frame, nLeds LED frames, then a tail word that
    // either closes the string cleanly or must be flagged as an error
    task automatic applyStimulus(input int nLeds, input logic [31:0] tail,
                                 input bit fixedCol, input bit tailOk);
        sendStart();
        for (int i = 0; i < nLeds; i++) begin
            sendLed(i, fixedCol);
        end
        pushEvt(tailOk ? KEND : KERR, 0, 0, 0, 0, 0);
        sendWord(tail);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event pulse
    always @(negedge clk) begin
        int   n;
        int   kind;
        evt_t e;
        if (rstN === 1'b1) begin
            n = int'(ledValid) + int'(startSeen) + int'(endSeen) + int'(protoErr);
            if (n > 0) begin
                checkOutput("pulse exclusivity", n, 1);
                kind = ledValid ? KLED : startSeen ? KSTART : endSeen ? KEND : KERR;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected event kind", kind, -1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("event kind", kind, e.kind);
                    if (kind == KLED && e.kind == KLED) begin
                        checkOutput("led_index", int'(ledIndex), e.idx);
                        checkOutput("bright", int'(bright), e.br);
                        checkOutput("blue", int'(blue), e.bl);
                        checkOutput("green", int'(green), e.gr);
                        checkOutput("red", int'(red), e.rd);
                    end
                    checkOutput("in_string", int'(inString),
                                (e.kind == KSTART || e.kind == KLED) ? 1 : 0);
                end
            end
        end
    end

    initial begin
        logic [6:0]  junk;
        logic [31:0] w;
        int          br, bl, gr, rd;

        rstN = 1'b0;
        mosi = 1'b0;
        sck  = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] clean string with fixed colours");
        applyStimulus(46, 32'hFFFF_FFFF, 1'b1, 1'b1);

        $display("[TB] junk bits before start frame");
        junk = 7'b1011001;
        for (int i = 6; i >= 0; i--) begin
            sendBit(junk[i]);
        end
        applyStimulus(46, 32'hFFFF_FFFF, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            sendBit(1'b1);
        end

        $display("[TB] bad word after three LEDs, then restart inside a string");
        applyStimulus(3, 32'h1234_5678, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("in_string after bad word", int'(inString), 0);
        sendStart();
        sendLed(0, 1'b0);
        sendLed(1, 1'b0);
        applyStimulus(46, 32'hFFFF_FFFF, 1'b0, 1'b1);

        $display("[TB] corrupted end frame");
        applyStimulus(46, 32'hFFFF_0000, 1'b0, 1'b0);

        $display("[TB] sck gap inside an LED frame");
        sendStart();
        br = $urandom_range(0, 31);
        bl = $urandom_range(0, 255);
        gr = $urandom_range(0, 255);
        rd = $urandom_range(0, 255);
        w  = ledWord(br, bl, gr, rd);
        for (int i = 31; i >= 15; i--) begin
            sendBit(w[i]);
        end
`ifdef DOLED_RX_TIMEOUT_EN
        pushEvt(KERR, 0, 0, 0, 0, 0);
        repeat (4300) @(negedge clk);
        checkOutput("in_string after timeout", int'(inString), 0);
`else
        repeat (4300) @(negedge clk);
        checkOutput("in_string across gap", int'(inString), 1);
        pushEvt(KLED, 0, br, bl, gr, rd);
        for (int i = 14; i >= 0; i--) begin
            sendBit(w[i]);
        end
        pushEvt(KERR, 0, 0, 0, 0, 0);
        sendWord(32'h1234_5678);
`endif
        repeat (4) @(negedge clk);

        $display("[TB] reset in the middle of an LED frame");
        sendStart();
        sendLed(0, 1'b0);
        w = ledWord(31, 255, 255, 255);
        for (int i = 31; i >= 22; i--) begin
            sendBit(w[i]);
        end
        repeat (4) @(negedge clk);
        checkOutput("pending before reset", expQ.size(), 0);
        rstN = 1'b0;
        #1;
        checkAllZero("mid-frame reset");
        expQ.delete();
        @(negedge clk);
        rstN = 1'b1;
        mosi = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(46, 32'hFFFF_FFFF, 1'b0, 1'b1);

        repeat (50) @(negedge clk);
        checkOutput("pending events at end", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/doled_rx.md
# doled_rx

Receive-side decoder for the LED-string SPI stream produced by `doled`. It oversamples `mosi`/`sck` on the system clock and aligns to the 32-bit start frame. Each LED frame is decoded into brightness and blue/green/red fields with an LED index, and the end frame is checked. It sits on the wand side of a loopback for bench self-check, or in front of a daisy-chained second wand, and lets the team verify `dostring_wave` output in hardware.

## Interface
- `LED_COUNT`, 46: LED frames expected between the start frame and the end frame.
- `IDLE_TIMEOUT`, 4096: system clocks with no `sck` rising edge before a partial frame is abandoned.
- `doled_rx_clk` in 1: system clock, 100 MHz.
- `doled_rx_reset_n` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `mosi` in 1: serial data, asynchronous to clock.
- `sck` in 1: serial clock, asynchronous to clock, data valid on rising edge.
- `led_valid` out 1: one-cycle pulse, LED frame decoded.
- `led_index` out 8: 0-based index of the decoded LED in the current string.
- `bright` out 5: global brightness field.
- `blue`, `green`, `red` out 8 each: colour fields.
- `start_seen` out 1: one-cycle pulse, start frame aligned.
- `end_seen` out 1: one-cycle pulse, valid end frame received.
- `proto_err` out 1: one-cycle pulse, protocol violation.
- `in_string` out 1: level, high between `start_seen` and the end of the string (end frame, error or timeout).

## Operation
- Synchroniser and edge detect:
  - `sck` and `mosi` each pass through a 2-flop synchroniser.
  - A third `sck` flop gives rise detect.
  - On a detected rise, the synchronised `mosi` shifts into `shreg[31:0]` MSB first, and `bitcnt` (5 bits) increments.
- Frame layout, MSB first: [31:29] = 3'b111, [28:24] bright, [23:16] blue, [15:8] green, [7:0] red. The start frame is 32'h0 and the end frame is 32'hFFFFFFFF.
- HUNT (reset state):
  - Sliding window; `bitcnt` is ignored.
  - When the window after a shift equals 32'h0: pulse `start_seen`, clear `bitcnt` and `led_index`, go to LEDS.
- LEDS:
  - Evaluate the word when `bitcnt` wraps 31→0.
  - [31:29] == 3'b111: latch the fields, pulse `led_valid` with the current `led_index`, then increment `led_index`.
  - Once `LED_COUNT` frames are decoded, go to END.
  - Word == 32'h0: treat as re-start. Pulse `start_seen`, reset `led_index` to 0, stay in LEDS.
  - Any other word: pulse `proto_err`, go to HUNT.
- END, next 32 bits:
  - == 32'hFFFFFFFF: pulse `end_seen`, go to HUNT.
  - Anything else: pulse `proto_err`, go to HUNT.
- Extra trailing ones after the end frame are consumed in HUNT without error.
- `in_string` = (state != HUNT).
- Field outputs hold their last value until the next `led_valid`. `led_index` saturates at 255; `LED_COUNT` ≤ 255 is required.

## Timing
- Reset (asynchronous assert): all outputs 0, state HUNT, `shreg`/`bitcnt`/`led_index`/timeout counter 0, synchroniser flops 0.
- Reset mid-frame: partial data is discarded; after release, the decoder re-hunts.
- `sck` rise to internal shift: 3 clocks. `sck` high and low must each be ≥ 3 clocks; shorter pulses are unsupported.
- Latency: pulses and field updates are registered 1 clock after the shift that completes the word.
- `led_valid`, `start_seen`, `end_seen` and `proto_err` are mutually exclusive within a cycle.
- The timeout counter clears on every detected rise and counts otherwise. Reaching `IDLE_TIMEOUT`:
  - In LEDS/END, or in HUNT with at least one bit shifted: pulse `proto_err` (except in HUNT), clear `shreg`/`bitcnt`, go to HUNT.
  - The counter then holds until the next rise.
- A rise and timeout in the same cycle: the rise wins and the counter clears.

## Configuration
- `DOLED_RX_TIMEOUT_EN` defined: the idle timeout above is built.
- Not defined: no timeout counter, `IDLE_TIMEOUT` is unused, and partial frames persist indefinitely across `sck` gaps.

## Test plan
- Reset, then start frame + 46 frames {111,5'h1F,8'h80,8'h02,8'h80} + 32'hFFFFFFFF → one `start_seen`; 46 `led_valid` with `led_index` 0..45, bright=31, blue=0x80, green=0x02, red=0x80; one `end_seen`; no `proto_err`.
- 7 junk bits (1011001) before the start frame → alignment still achieved; same decode as scenario 1.
- Start frame + 3 LED frames + word 32'h12345678 → `led_valid` ×3, then `proto_err`; `in_string`=0; a following clean string decodes from index 0.
- Start + 46 LEDs + 32'hFFFF0000 → `proto_err` in place of `end_seen`.
- With `DOLED_RX_TIMEOUT_EN`: 17 bits of an LED frame, then 4096 idle clocks → `proto_err` and HUNT. Without the macro: no error, and the frame completes when the remaining 15 bits arrive.
- Assert `doled_rx_reset_n` low for 1 clock mid-LED-frame → all outputs read 0 immediately; the next full string decodes correctly.
